// File: rtl/rv32i_multicycle_controller.sv
// -----------------------------------------------------------------------------
// rv32i_multicycle_controller
//
// Main control FSM for the RV32I multicycle core. Instructions are sequenced
// one at a time through fetch, decode, execute, memory and writeback. Each
// cycle the FSM drives the datapath mux selects, the architectural write
// enables and the ALU operation class. Illegal opcodes (and unsupported
// branch funct3 values) trap into a sticky ERROR state that only reset leaves.
//
// Optional feature macro: RV32I_CTRL_UTYPE_EN
//   defined   : LUI / AUIPC decode to their own execute states.
//   undefined : LUI / AUIPC states are not built; those opcodes trap to ERROR.
//
// Parameters
//   PC_START_STATE_FETCH : 1 = leave reset in FETCH, 0 = leave reset parked in
//                          ERROR (only a further reset exits).
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous, active-low reset
//   ena        in   1 = advance FSM, 0 = hold state and suppress all writes
//   op         in   instr[6:0], valid from DECODE onward
//   funct3     in   instr[14:12]
//   zero       in   ALU zero flag
//   pc_write   out  PC write enable (pc_update | branch & taken)
//   ir_write   out  latch instruction register and PC_old
//   reg_write  out  register-file write enable
//   mem_write  out  data-memory write enable
//   adr_src    out  memory address select: 0 = PC, 1 = result
//   alu_src_a  out  ALU A select: 00 PC, 01 PC_old, 10 rs1, 11 zero
//   alu_src_b  out  ALU B select: 00 rs2, 01 imm_ext, 10 constant 4
//   res_src    out  result select: 00 alu_out, 01 data, 10 alu_result
//   alu_op     out  ALU class: 00 add, 01 sub, 10 decode from funct
//   imm_src    out  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U
//   illegal    out  1 while parked in ERROR
//   retire     out  one-cycle pulse on the last cycle of each instruction
// -----------------------------------------------------------------------------
module rv32i_multicycle_controller #(
    parameter logic PC_START_STATE_FETCH = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       zero,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] res_src,
    output logic [1:0] alu_op,
    output logic [2:0] imm_src,
    output logic       illegal,
    output logic       retire
);

    // Opcodes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    // Mux select encodings
    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_PC_OLD = 2'b01;
    localparam logic [1:0] SRC_A_RS1    = 2'b10;
    localparam logic [1:0] SRC_A_ZERO   = 2'b11;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALU_OUT    = 2'b00;
    localparam logic [1:0] RES_DATA       = 2'b01;
    localparam logic [1:0] RES_ALU_RESULT = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // ERROR keeps encoding 15 in both builds so a parked core reads the same.
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADR   = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_JALR_ADR  = 4'd11,
        S_JALR      = 4'd12,
`ifdef RV32I_CTRL_UTYPE_EN
        S_LUI       = 4'd13,
        S_AUIPC     = 4'd14,
`endif
        S_ERROR     = 4'd15
    } state_t;

    localparam state_t RESET_STATE = PC_START_STATE_FETCH ? S_FETCH : S_ERROR;

    state_t state;
    state_t state_next;

    // Raw per-state controls before ena / reset gating
    logic pc_update;
    logic branch;
    logic ir_w;
    logic reg_w;
    logic mem_w;
    logic retire_w;
    logic illegal_st;
    logic taken;
    logic branch_legal;
    logic en_gate;

    assign taken        = (funct3 == F3_BEQ) ? zero : ~zero;
    assign branch_legal = (funct3 == F3_BEQ) || (funct3 == F3_BNE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RESET_STATE;
        end else if (ena) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_update  = 1'b0;
        branch     = 1'b0;
        ir_w       = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        retire_w   = 1'b0;
        illegal_st = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RS2;
        res_src    = RES_ALU_OUT;
        alu_op     = ALU_ADD;

        case (state)
            S_FETCH: begin
                ir_w       = 1'b1;
                alu_src_b  = SRC_B_FOUR;
                res_src    = RES_ALU_RESULT;
                pc_update  = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                // PC_old + imm lands in alu_out for BRANCH / JAL to use
                alu_src_a = SRC_A_PC_OLD;
                alu_src_b = SRC_B_IMM;
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEM_ADR;
                    OP_R:              state_next = S_EXEC_R;
                    OP_IMM:            state_next = S_EXEC_I;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = S_JALR_ADR;
`ifdef RV32I_CTRL_UTYPE_EN
                    OP_LUI:            state_next = S_LUI;
                    OP_AUIPC:          state_next = S_AUIPC;
`endif
                    default:           state_next = S_ERROR;
                endcase
            end
            S_MEM_ADR: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                // op[5] separates store (0100011) from load (0000011)
                state_next = op[5] ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                adr_src    = 1'b1;
                state_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                res_src    = RES_DATA;
                reg_w      = 1'b1;
                retire_w   = 1'b1;
                state_next = S_FETCH;
            end
            S_MEM_WRITE: begin
                adr_src    = 1'b1;
                mem_w      = 1'b1;
                retire_w   = 1'b1;
                state_next = S_FETCH;
            end
            S_EXEC_R: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_RS2;
                alu_op     = ALU_FUNCT;
                state_next = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                alu_op     = ALU_FUNCT;
                state_next = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_w      = 1'b1;
                retire_w   = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_RS2;
                alu_op    = ALU_SUB;
                retire_w  = 1'b1;
                // Only beq / bne are supported; anything else traps and
                // must not redirect the PC on the way out.
                if (branch_legal) begin
                    branch     = 1'b1;
                    state_next = S_FETCH;
                end else begin
                    state_next = S_ERROR;
                end
            end
            S_JAL, S_JALR: begin
                // alu_out holds the target; ALU computes the link PC_old+4
                alu_src_a  = SRC_A_PC_OLD;
                alu_src_b  = SRC_B_FOUR;
                pc_update  = 1'b1;
                state_next = S_ALU_WB;
            end
            S_JALR_ADR: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                state_next = S_JALR;
            end
`ifdef RV32I_CTRL_UTYPE_EN
            S_LUI: begin
                alu_src_a  = SRC_A_ZERO;
                alu_src_b  = SRC_B_IMM;
                state_next = S_ALU_WB;
            end
            S_AUIPC: begin
                alu_src_a  = SRC_A_PC_OLD;
                alu_src_b  = SRC_B_IMM;
                state_next = S_ALU_WB;
            end
`endif
            S_ERROR: begin
                illegal_st = 1'b1;
                state_next = S_ERROR;
            end
            default: begin
                state_next = S_ERROR;
            end
        endcase
    end

    always_comb begin
        case (op)
            OP_LOAD, OP_IMM, OP_JALR: imm_src = IMM_I;
            OP_STORE:                 imm_src = IMM_S;
            OP_BRANCH:                imm_src = IMM_B;
            OP_JAL:                   imm_src = IMM_J;
            OP_LUI, OP_AUIPC:         imm_src = IMM_U;
            default:                  imm_src = IMM_I;
        endcase
    end

    // Reset is folded in combinationally so no write or retire can escape
    // between the asynchronous assert and the next clock edge.
    assign en_gate   = ena & rst;
    assign pc_write  = (pc_update | (branch & taken)) & en_gate;
    assign ir_write  = ir_w & en_gate;
    assign reg_write = reg_w & en_gate;
    assign mem_write = mem_w & en_gate;
    assign retire    = retire_w & en_gate;
    assign illegal   = illegal_st & rst;

endmodule

// File: tb/tb_rv32i_multicycle_controller.sv
module tb_rv32i_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       zero;
    logic       pc_write, ir_write, reg_write, mem_write, adr_src;
    logic [1:0] alu_src_a, alu_src_b, res_src, alu_op;
    logic [2:0] imm_src;
    logic       illegal, retire;

    rv32i_multicycle_controller dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .op        (op),
        .funct3    (funct3),
        .zero      (zero),
        .pc_write  (pc_write),
        .ir_write  (ir_write),
        .reg_write (reg_write),
        .mem_write (mem_write),
        .adr_src   (adr_src),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .res_src   (res_src),
        .alu_op    (alu_op),
        .imm_src   (imm_src),
        .illegal   (illegal),
        .retire    (retire)
    );

    always #5 clk = ~clk;

    // One expected output vector per instruction cycle
    typedef struct packed {
        logic       pcw;
        logic       irw;
        logic       rw;
        logic       mw;
        logic       adr;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] rs;
        logic [1:0] aop;
        logic       ill;
        logic       ret;
    } rec_t;

    rec_t  exp_q[$];
    bit    model_err = 1'b0;
    string cur_name  = "reset";
    int    n_assert  = 0;
    int    n_fail    = 0;

    function automatic rec_t mk(input logic pcw, irw, rw, mw, adr,
                                input logic [1:0] sa, sb, rs, aop,
                                input logic ill, ret);
        rec_t r;
        r.pcw = pcw; r.irw = irw; r.rw = rw; r.mw = mw; r.adr = adr;
        r.sa = sa; r.sb = sb; r.rs = rs; r.aop = aop; r.ill = ill; r.ret = ret;
        return r;
    endfunction

    // Cycle vectors written straight from the output lists of each step
    rec_t R_FETCH, R_DECODE, R_ADDR_RS1, R_MEMRD, R_MEMWB, R_MEMWR, R_EXR, R_EXI;
    rec_t R_WB, R_LINK, R_LUI, R_AUIPC, R_ERR;
    initial begin
        R_FETCH    = mk(1,1,0,0,0, 2'b00,2'b10,2'b10,2'b00, 0,0);
        R_DECODE   = mk(0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 0,0);
        R_ADDR_RS1 = mk(0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 0,0);
        R_MEMRD    = mk(0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 0,0);
        R_MEMWB    = mk(0,0,1,0,0, 2'b00,2'b00,2'b01,2'b00, 0,1);
        R_MEMWR    = mk(0,0,0,1,1, 2'b00,2'b00,2'b00,2'b00, 0,1);
        R_EXR      = mk(0,0,0,0,0, 2'b10,2'b00,2'b00,2'b10, 0,0);
        R_EXI      = mk(0,0,0,0,0, 2'b10,2'b01,2'b00,2'b10, 0,0);
        R_WB       = mk(0,0,1,0,0, 2'b00,2'b00,2'b00,2'b00, 0,1);
        R_LINK     = mk(1,0,0,0,0, 2'b01,2'b10,2'b00,2'b00, 0,0);
        R_LUI      = mk(0,0,0,0,0, 2'b11,2'b01,2'b00,2'b00, 0,0);
        R_AUIPC    = mk(0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 0,0);
        R_ERR      = mk(0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 1,0);
    end

    function automatic logic [2:0] model_imm(input logic [6:0] o);
        if (o == 7'b0000011 || o == 7'b0010011 || o == 7'b1100111) return 3'b000;
        if (o == 7'b0100011) return 3'b001;
        if (o == 7'b1100011) return 3'b010;
        if (o == 7'b1101111) return 3'b011;
        if (o == 7'b0110111 || o == 7'b0010111) return 3'b100;
        return 3'b000;
    endfunction

    // Expected cycle list for one whole instruction
    task automatic push_instr(input logic [6:0] o, input logic [2:0] f3, input logic z);
        bit tk;
        exp_q.push_back(R_FETCH);
        exp_q.push_back(R_DECODE);
        case (o)
            7'b0000011: begin exp_q.push_back(R_ADDR_RS1); exp_q.push_back(R_MEMRD); exp_q.push_back(R_MEMWB); end
            7'b0100011: begin exp_q.push_back(R_ADDR_RS1); exp_q.push_back(R_MEMWR); end
            7'b0110011: begin exp_q.push_back(R_EXR); exp_q.push_back(R_WB); end
            7'b0010011: begin exp_q.push_back(R_EXI); exp_q.push_back(R_WB); end
            7'b1100011: begin
                if (f3 == 3'b000 || f3 == 3'b001) begin
                    tk = (f3 == 3'b000) ? z : !z;
                    exp_q.push_back(mk(tk,0,0,0,0, 2'b10,2'b00,2'b00,2'b01, 0,1));
                end else begin
                    exp_q.push_back(mk(0,0,0,0,0, 2'b10,2'b00,2'b00,2'b01, 0,1));
                    model_err = 1'b1;
                end
            end
            7'b1101111: begin exp_q.push_back(R_LINK); exp_q.push_back(R_WB); end
            7'b1100111: begin exp_q.push_back(R_ADDR_RS1); exp_q.push_back(R_LINK); exp_q.push_back(R_WB); end
`ifdef RV32I_CTRL_UTYPE_EN
            7'b0110111: begin exp_q.push_back(R_LUI); exp_q.push_back(R_WB); end
            7'b0010111: begin exp_q.push_back(R_AUIPC); exp_q.push_back(R_WB); end
`endif
            default: model_err = 1'b1;
        endcase
    endtask

    // Compare process: every cycle out of reset with an expectation pending
    always @(negedge clk) begin
        rec_t e;
        rec_t a;
        if (rst) begin
            if (exp_q.size() > 0 || model_err) begin
                e = (exp_q.size() > 0) ? exp_q[0] : R_ERR;
                if (!ena) begin
                    e.pcw = 1'b0; e.irw = 1'b0; e.rw = 1'b0; e.mw = 1'b0; e.ret = 1'b0;
                end
                a = {pc_write, ir_write, reg_write, mem_write, adr_src,
                     alu_src_a, alu_src_b, res_src, alu_op, illegal, retire};
                n_assert++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL %s outputs t=%0t: got %h expected %h", cur_name, $time, a, e);
                end
                if (ena && exp_q.size() > 0) exp_q.delete(0);
            end
            n_assert++;
            if (imm_src !== model_imm(op)) begin
                n_fail++;
                $display("FAIL %s imm_src: got %0d expected %0d", cur_name, imm_src, model_imm(op));
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Starts and ends at posedge+1 with the FSM sitting in FETCH
    task automatic run_instr(input string nm, input logic [6:0] o, input logic [2:0] f3,
                             input logic z, input int exp_cpi, input int exp_pcw_ret,
                             input int hold_at);
        int n;
        bit done;
        int pcw_ret;
        cur_name = nm;
        exp_q.delete();
        model_err = 1'b0;
        op = o; funct3 = f3; zero = z;
        push_instr(o, f3, z);
        n = 0; done = 1'b0; pcw_ret = -1;
        for (int k = 0; k < 16 && !done; k++) begin
            ena = (k >= hold_at && k < hold_at + 3) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (ena) n++;
            if (retire) begin done = 1'b1; pcw_ret = int'(pc_write); end
            @(posedge clk); #1;
        end
        ena = 1'b1;
        chk({nm, " cycles"}, done ? n : -1, exp_cpi);
        chk({nm, " pc_write at retire"}, pcw_ret, exp_pcw_ret);
    endtask

    task automatic release_reset();
        exp_q.delete();
        model_err = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic run_err(input string nm, input logic [6:0] o, input logic [2:0] f3, input logic z);
        cur_name = nm;
        exp_q.delete();
        model_err = 1'b0;
        op = o; funct3 = f3; zero = z; ena = 1'b1;
        push_instr(o, f3, z);
        repeat (14) @(posedge clk);
        @(negedge clk);
        chk({nm, " illegal sticky"}, int'(illegal), 1);
        #1 rst = 1'b0;
        #1;
        chk({nm, " illegal in reset"}, int'(illegal), 0);
        chk({nm, " enables in reset"}, int'({pc_write, ir_write, reg_write, mem_write, retire}), 0);
        release_reset();
    endtask

    initial begin
        rst = 1'b0; ena = 1'b1; op = 7'b0110011; funct3 = 3'b000; zero = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("reset enables", int'({pc_write, ir_write, reg_write, mem_write, retire}), 0);
            chk("reset illegal", int'(illegal), 0);
        end
        @(posedge clk); #1 rst = 1'b1;

        run_instr("rtype",   7'b0110011, 3'b000, 1'b0, 4, 0, 99);
        run_instr("load",    7'b0000011, 3'b010, 1'b0, 5, 0, 99);
        run_instr("store",   7'b0100011, 3'b010, 1'b0, 4, 0, 99);
        run_instr("opimm",   7'b0010011, 3'b000, 1'b0, 4, 0, 99);
        run_instr("beq z1",  7'b1100011, 3'b000, 1'b1, 3, 1, 99);
        run_instr("beq z0",  7'b1100011, 3'b000, 1'b0, 3, 0, 99);
        run_instr("bne z1",  7'b1100011, 3'b001, 1'b1, 3, 0, 99);
        run_instr("bne z0",  7'b1100011, 3'b001, 1'b0, 3, 1, 99);
        run_instr("jal",     7'b1101111, 3'b000, 1'b0, 4, 0, 99);
        run_instr("jalr",    7'b1100111, 3'b000, 1'b0, 5, 0, 99);
        run_instr("rtype hold exec", 7'b0110011, 3'b000, 1'b0, 4, 0, 2);
        run_instr("jal hold fetch",  7'b1101111, 3'b000, 1'b0, 4, 0, 0);
        run_instr("beq hold branch", 7'b1100011, 3'b000, 1'b1, 3, 1, 2);
`ifdef RV32I_CTRL_UTYPE_EN
        run_instr("lui",     7'b0110111, 3'b000, 1'b0, 4, 0, 99);
        run_instr("auipc",   7'b0010111, 3'b000, 1'b0, 4, 0, 99);
`else
        run_err("lui trap",  7'b0110111, 3'b000, 1'b0);
        run_instr("after lui trap", 7'b0110011, 3'b000, 1'b0, 4, 0, 99);
`endif
        run_err("branch f3=100", 7'b1100011, 3'b100, 1'b1);
        run_instr("after branch trap", 7'b0000011, 3'b000, 1'b0, 5, 0, 99);
        run_err("op zero", 7'b0000000, 3'b000, 1'b0);
        run_instr("after op trap", 7'b0100011, 3'b000, 1'b0, 4, 0, 99);

        // Abandon a load in MEM_READ: its MEM_WB write must never appear
        cur_name = "mid reset";
        exp_q.delete();
        op = 7'b0000011; funct3 = 3'b010; zero = 1'b0;
        push_instr(op, funct3, zero);
        repeat (3) begin @(posedge clk); #1; end
        #2 rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("mid reset enables", int'({pc_write, ir_write, reg_write, mem_write, retire}), 0);
        end
        release_reset();
        run_instr("after mid reset", 7'b0110011, 3'b000, 1'b0, 4, 0, 99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rv32i_multicycle_controller.md
# rv32i_multicycle_controller

Main control FSM for the RV32I multicycle core. It sequences the core's datapath one instruction at a time through fetch, decode, execute, memory and writeback. Each cycle it drives the mux selects, write enables and ALU operation class that the core's datapath muxes and ALU decoder consume. It also gates all architectural writes with `ena` and traps illegal opcodes into a sticky error state.

## Interface
- `PC_START_STATE_FETCH`, 1: 1 means leave reset in FETCH; 0 means leave reset in ERROR (parked core; only reset exits).
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: **asynchronous, active-low** reset.
- `ena` in 1: 1 = advance FSM; 0 = hold state, force all write enables to 0.
- `op` in 7: `instr[6:0]`, valid from DECODE onward.
- `funct3` in 3: `instr[14:12]`.
- `zero` in 1: ALU zero flag.
- `pc_write` out 1: `pc_update | (branch & taken)`, gated by `ena`.
- `ir_write` out 1: latch instruction and PC_old.
- `reg_write` out 1: register-file write enable.
- `mem_write` out 1: memory write enable.
- `adr_src` out 1: memory address select; 0 = PC, 1 = result.
- `alu_src_a` out 2: ALU A select; 00 = PC, 01 = PC_old, 10 = rs1 data, 11 = constant 0.
- `alu_src_b` out 2: ALU B select; 00 = rs2 data, 01 = imm_ext, 10 = constant 4.
- `res_src` out 2: result select; 00 = alu_out, 01 = data, 10 = alu_result.
- `alu_op` out 2: ALU operation class; 00 = add, 01 = sub, 10 = decode from funct.
- `imm_src` out 3: immediate format; 000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- `illegal` out 1: 1 while in ERROR.
- `retire` out 1: one-cycle pulse on the final cycle of each instruction.

## Operation
- States: FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, BRANCH, JAL, JALR_ADR, JALR, LUI, AUIPC, ERROR.
- Any output not listed for a state is 0.
- **FETCH**
  - Outputs: adr_src=0, ir_write=1, src_a=PC, src_b=4, alu_op=add, res_src=10, pc_update=1.
  - Next: DECODE.
- **DECODE**
  - Outputs: src_a=PC_old, src_b=imm, alu_op=add. This precomputes the branch/JAL target into alu_out.
  - Next state by `op`:
    - 0000011 or 0100011 → MEM_ADR
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR_ADR
    - 0110111 → LUI
    - 0010111 → AUIPC
    - anything else → ERROR
- **MEM_ADR**: src_a=rs1, src_b=imm, add. Next: MEM_READ if op[5]=0, else MEM_WRITE.
- **MEM_READ**: adr_src=1, res_src=00. Next: MEM_WB.
- **MEM_WB**: res_src=01, reg_write=1, retire. Next: FETCH.
- **MEM_WRITE**: adr_src=1, res_src=00, mem_write=1, retire. Next: FETCH.
- **EXEC_R**: src_a=rs1, src_b=rs2, alu_op=10. Next: ALU_WB.
- **EXEC_I**: src_a=rs1, src_b=imm, alu_op=10. Next: ALU_WB.
- **ALU_WB**: res_src=00, reg_write=1, retire. Next: FETCH.
- **BRANCH**
  - Outputs: src_a=rs1, src_b=rs2, alu_op=sub, res_src=00, branch=1, retire.
  - taken = zero when funct3=000 (beq); taken = !zero when funct3=001 (bne).
  - Any other funct3 → ERROR instead of FETCH, with branch forced to 0.
- **JAL**: src_a=PC_old, src_b=4, add, res_src=00, pc_update=1. Next: ALU_WB (writes PC_old+4).
- **JALR_ADR**: src_a=rs1, src_b=imm, add. Next: JALR.
- **JALR**: same outputs as JAL. Next: ALU_WB.
- **LUI**: src_a=0, src_b=imm, add. Next: ALU_WB.
- **AUIPC**: src_a=PC_old, src_b=imm, add. Next: ALU_WB.
- **ERROR**: all enables 0, illegal=1. Exits only via reset.
- `imm_src` is decoded combinationally from `op` in every state:
  - I: load, OP-IMM, JALR
  - S: store
  - B: branch
  - J: JAL
  - U: LUI, AUIPC
  - default: 000

## Timing
- Reset (async assert, any state): state = FETCH (or ERROR per parameter). All enables, `retire` and `illegal` are 0 while reset is asserted.
- Release is synchronous to the next `clk` rise. The first FETCH issues on the first edge after release.
- All outputs are Moore from the state register, with two exceptions that are combinational within the cycle:
  - `pc_write` in BRANCH (depends on `zero`)
  - `imm_src` (depends on `op`)
- Cycles per instruction:
  - 3: branch
  - 4: R-type, OP-IMM, store, JAL, LUI, AUIPC
  - 5: load, JALR
- `ena=0` in any state: state holds and pc_write, ir_write, reg_write, mem_write and retire are 0. Mux selects keep their state values. Resuming with `ena=1` continues from the same state with no cycle lost or repeated.
- Reset asserted mid-instruction: the partial instruction is abandoned and no write enable is asserted after the asserting edge.

## Configuration
- `RV32I_CTRL_UTYPE_EN`
  - Defined: LUI/AUIPC decode to their states as above.
  - Undefined: the LUI and AUIPC states are omitted, and opcodes 0110111/0010111 decode to ERROR.

## Test plan
- Reset low, then high, with op=0110011: state sequence FETCH, DECODE, EXEC_R, ALU_WB, FETCH. ir_write=1 only in cycle 1, reg_write=1 only in cycle 4, retire pulses once.
- Load (op=0000011) then store (op=0100011):
  - Load takes 5 cycles, with adr_src=1 in MEM_READ and res_src=01 with reg_write in MEM_WB.
  - Store takes 4 cycles, with mem_write=1 exactly once.
- beq (funct3=000):
  - zero=1 → pc_write=1 in BRANCH.
  - zero=0 → pc_write=0.
  - bne gives the inverse.
  - funct3=100 → illegal=1 the following cycle, and it stays set.
- JAL: pc_write in FETCH and JAL, reg_write in ALU_WB. JALR: 5 cycles, with alu_src_a=10 in JALR_ADR.
- Hold `ena=0` for 3 cycles in EXEC_R: state is unchanged and all enables are 0. ALU_WB follows on the first cycle with `ena=1`.
- op=0000000: ERROR after DECODE, illegal=1 persists over 10 cycles. Async reset clears it to FETCH. With `RV32I_CTRL_UTYPE_EN` undefined, op=0110111 also reaches ERROR.
